toggle_bank_arbiter: RTL
========================

// Module: toggle_bank_arbiter
// PURPOSE
//  Round-robin scheduler for a bank of N single-bit toggle lanes shared by N requesters.
//  Each cycle it grants at most one requester, then applies that requester's op to its lane one cycle later.
//  Per-lane ops are toggle or clear; a global clear and a hold input sit above arbitration.
//  Sits between requester logic and the lane bank; the bank state is owned here and exported on a.
// PARAMETERS
//  N      32  number of lanes/requesters (2..64)
//  CNT_W  16  width of saturating grant counter
// PORTS
//  c      in   1         clock, rising edge
//  r      in   1         reset, asynchronous, active-high
//  req    in   N         level request per lane; held until gnt seen
//  op     in   N         per-lane op, sampled with req: 0=toggle, 1=clear
//  hold   in   1         1 = no new grant this cycle
//  clr    in   1         synchronous global clear of bank
//  gnt    out  N         registered one-hot grant pulse (or all-zero)
//  gidx   out  $clog2(N) index of last issued grant
//  a      out  N         lane bank state
//  busy   out  1         1 while any unmasked req pending or an op is in flight
//  ngnt   out  CNT_W     total grants issued, saturates at all-ones
// BEHAVIOUR
//  - Reset (async on r=1): gnt=0, gidx=0, a=0, ngnt=0, busy=0, rr pointer=0, pending op stage empty.
//  - Cycle k: eligible = req & ~gnt (lane granted in k-1 excluded, as its req is still high).
//    If hold=0 and eligible!=0: pick first set bit at/after ptr (wrap N-1 -> 0).
//    At edge: gnt<=onehot(pick), gidx<=pick, ptr<=pick+1 mod N, latch op[pick] into stage.
//    Else gnt<=0, ptr and gidx unchanged.
//  - Cycle k+1 (gnt visible): requester may drop req. At edge k+1 the staged op is applied:
//    toggle: a[pick]<=~a[pick]; clear: a[pick]<=0. Latency req->gnt 1 cycle, req->a 2 cycles.
//  - Throughput: one grant per cycle; one requester holding req continuously gets at most every other cycle.
//  - clr=1: a<=0 at edge, staged op discarded (not applied); arbitration and gnt proceed normally.
//    clr with grant the same cycle: grant issues, its op applies next edge on top of cleared bank.
//  - hold=1: gnt<=0 next edge; a staged op from previous grant still applies.
//  - ngnt increments on each issued grant, sticks at 2^CNT_W-1.
//  - busy = (req & ~gnt)!=0 | stage valid; combinational from registers and req.
//  - Single-lane toggles produce single-bit changes in a; no other bits move.
//  - r asserted mid-operation: in-flight staged op dropped, all state to reset values immediately.
// STRUCTURE
//  - toggle_bank_pkg: typedef enum logic {OP_TOGGLE=1'b0, OP_CLEAR=1'b1} op_e; localparam N_DEFAULT=32.
//  - Sub-module rr_pick: combinational round-robin picker (eligible, ptr -> valid, idx), params N.
//  - Top holds ptr, gnt/gidx regs, op stage (valid, idx, op), bank a, counter.
// TESTING
//  - Reset: r=1 mid-stream with stage valid -> a=0, gnt=0, ngnt=0 same cycle; nothing applied after release.
//  - Single toggle: req[5]=1,op=0 one pulse-held -> gnt=0x20 after 1 edge, a[5]=1 after 2 edges, ngnt=1.
//  - Fairness: req=0xFFFFFFFF held, op=0 -> gidx 0,1,2..31,0 over 32 grants; a=0xFFFFFFFF after 33 edges.
//  - Wrap: ptr=30, req bits {1,30} -> grants 30 then 1; ptr ends at 2.
//  - clr vs op: grant lane 3 toggle, clr=1 on apply edge -> a=0 (toggle discarded); hold=1 -> gnt=0.
//  - Saturation: CNT_W=4, 20 grants -> ngnt=15; clear op on lane with a=1 -> a bit 0.

Source files
------------

// File: rtl/toggle_bank_pkg.sv
// Shared types for the toggle bank arbiter: per-lane op encoding and default bank size.
package toggle_bank_pkg;

  typedef enum logic {
    OP_TOGGLE = 1'b0,
    OP_CLEAR  = 1'b1
  } op_e;

  localparam int N_DEFAULT = 32;

endpackage

// File: rtl/toggle_bank_arbiter_rr_pick.sv
// Combinational round-robin picker: first eligible lane at or after ptr, wrapping N-1 -> 0.
module rr_pick #(
  parameter int N  = 32,
  parameter int IW = $clog2(N)
) (
  input  logic [N-1:0]  eligible,
  input  logic [IW-1:0] ptr,
  output logic          valid,
  output logic [IW-1:0] idx
);

  always_comb begin
    int j;
    j     = 0;
    valid = 1'b0;
    idx   = '0;
    for (int i = 0; i < N; i++) begin
      j = int'(ptr) + i;
      if (j >= N) j = j - N;
      if (!valid && eligible[j]) begin
        valid = 1'b1;
        idx   = IW'(j);
      end
    end
  end

endmodule

// File: rtl/toggle_bank_arbiter.sv
// Round-robin grant of one requester per cycle; the winner's toggle/clear op lands on
// its lane of the owned bank one cycle after the grant.
module toggle_bank_arbiter
  import toggle_bank_pkg::*;
#(
  parameter int N     = N_DEFAULT,
  parameter int CNT_W = 16,
  parameter int IW    = $clog2(N)
) (
  input  logic             c,
  input  logic             r,
  input  logic [N-1:0]     req,
  input  logic [N-1:0]     op,
  input  logic             hold,
  input  logic             clr,
  output logic [N-1:0]     gnt,
  output logic [IW-1:0]    gidx,
  output logic [N-1:0]     a,
  output logic             busy,
  output logic [CNT_W-1:0] ngnt
);

  logic [IW-1:0] ptr;
  logic [N-1:0]  eligible;
  logic          pick_v;
  logic [IW-1:0] pick_idx;
  logic          grant;
  logic [N-1:0]  pick_onehot;

  logic          stage_v;
  logic [IW-1:0] stage_idx;
  op_e           stage_op;

  // The lane granted last cycle still holds req while it sees gnt, so mask it out.
  assign eligible    = req & ~gnt;
  assign grant       = pick_v & ~hold;
  assign pick_onehot = {{(N-1){1'b0}}, 1'b1} << pick_idx;
  assign busy        = (|eligible) | stage_v;

  rr_pick #(.N(N), .IW(IW)) u_pick (
    .eligible (eligible),
    .ptr      (ptr),
    .valid    (pick_v),
    .idx      (pick_idx)
  );

  always_ff @(posedge c or posedge r) begin
    if (r) begin
      ptr       <= '0;
      gnt       <= '0;
      gidx      <= '0;
      ngnt      <= '0;
      stage_v   <= 1'b0;
      stage_idx <= '0;
      stage_op  <= OP_TOGGLE;
      a         <= '0;
    end else begin
      if (grant) begin
        gnt       <= pick_onehot;
        gidx      <= pick_idx;
        ptr       <= (pick_idx == IW'(N-1)) ? '0 : pick_idx + IW'(1);
        stage_v   <= 1'b1;
        stage_idx <= pick_idx;
        stage_op  <= op_e'(op[pick_idx]);
        if (ngnt != '1) ngnt <= ngnt + CNT_W'(1);
      end else begin
        gnt     <= '0;
        stage_v <= 1'b0;
      end

      // A global clear wins over the staged op, which is dropped rather than applied.
      if (clr) begin
        a <= '0;
      end else if (stage_v) begin
        a[stage_idx] <= (stage_op == OP_CLEAR) ? 1'b0 : ~a[stage_idx];
      end
    end
  end

endmodule
